// File: rtl/fs_test_pkg.sv
// Shared definitions for the full_subtractor fault sequencer:
//   state_t     - sequencer FSM states
//   VECTORS     - the four stimulus vectors {A,B,Bin}, index k = 0..3
//   EXP_RESP    - fault-free response {D,Bout} for each vector
//   FC_*        - 4-bit fault codes 0..8
package fs_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE_WAIT,
    ST_SAMPLE,
    ST_FINISH
  } state_t;

  // Element [k] is vector k: 111, 110, 101, 100.
  localparam logic [3:0][2:0] VECTORS  = {3'b100, 3'b101, 3'b110, 3'b111};
  // Element [k] is the good response {D,Bout} to vector k.
  localparam logic [3:0][1:0] EXP_RESP = {2'b10, 2'b00, 2'b00, 2'b11};

  localparam logic [3:0] FC_NONE    = 4'd0;
  localparam logic [3:0] FC_A       = 4'd1;
  localparam logic [3:0] FC_B       = 4'd2;
  localparam logic [3:0] FC_BIN     = 4'd3;
  localparam logic [3:0] FC_A_B     = 4'd4;
  localparam logic [3:0] FC_B_BIN   = 4'd5;
  localparam logic [3:0] FC_A_BIN   = 4'd6;
  localparam logic [3:0] FC_A_B_BIN = 4'd7;
  localparam logic [3:0] FC_UNCLASS = 4'd8;

endpackage

// File: rtl/fs_fault_classifier.sv
// Combinational fault classifier.
//   i_idx  - vector index k (0..3) currently being sampled
//   i_d    - observed difference output
//   i_bout - observed borrow output
//   o_code - 0 when the response matches, else stuck-at diagnosis (1..8)
module fs_fault_classifier
  import fs_test_pkg::*;
(
  input  logic [1:0] i_idx,
  input  logic       i_d,
  input  logic       i_bout,
  output logic [3:0] o_code
);

  logic [1:0] w_resp;

  assign w_resp = {i_d, i_bout};

  always_comb begin
    o_code = FC_UNCLASS;
    if (w_resp == EXP_RESP[i_idx]) begin
      o_code = FC_NONE;
    end else begin
      case ({i_idx, w_resp})
        4'b00_01: o_code = FC_A;
        4'b00_10: o_code = FC_B_BIN;
        4'b01_10: o_code = FC_B;
        4'b01_11: o_code = FC_A_BIN;
        4'b10_10: o_code = FC_BIN;
        4'b10_11: o_code = FC_A_B;
        4'b11_00: o_code = FC_A_B_BIN;
        default:  o_code = FC_UNCLASS;
      endcase
    end
  end

endmodule

// File: rtl/fs_fault_sequencer.sv
// Diagnostic sequencer for a full_subtractor: applies four vectors, samples
// the DUT response after SETTLE cycles each, latches the first fault code.
//   clk, rst_n          - clock, asynchronous active-low reset
//   start               - single-cycle run request (honoured only in IDLE)
//   dut_d, dut_bout     - DUT responses
//   test_a/test_b/test_bin - registered stimulus into the DUT
//   busy                - high while the sequence runs
//   done                - one-cycle result-valid pulse
//   fault_code          - diagnosis, held until the next accepted start
//   fault_found         - fault_code != 0
module fs_fault_sequencer
  import fs_test_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dut_d,
  input  logic       dut_bout,
  output logic       test_a,
  output logic       test_b,
  output logic       test_bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] fault_code,
  output logic       fault_found
);

  localparam logic [3:0] LAST_WAIT = 4'(SETTLE - 1);

  state_t     r_state, w_next;
  logic [1:0] r_idx,   w_idx;
  logic [3:0] r_wait,  w_wait;
  logic [2:0] r_test,  w_test;
  logic       r_busy,  w_busy;
  logic       r_done,  w_done;
  logic [3:0] r_code,  w_code;
  logic       r_found;
  logic [3:0] w_class;

  fs_fault_classifier u_classifier (
    .i_idx  (r_idx),
    .i_d    (dut_d),
    .i_bout (dut_bout),
    .o_code (w_class)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // LOAD only presents vector 0; SAMPLE presents each following vector so
  // that every vector period is exactly SETTLE_WAIT(SETTLE) + SAMPLE(1).
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:        if (start) w_next = ST_LOAD;
      ST_LOAD:        w_next = ST_SETTLE_WAIT;
      ST_SETTLE_WAIT: if (r_wait == LAST_WAIT) w_next = ST_SAMPLE;
      ST_SAMPLE:      w_next = (r_idx == 2'd3) ? ST_FINISH : ST_SETTLE_WAIT;
      ST_FINISH:      w_next = ST_IDLE;
      default:        w_next = ST_IDLE;
    endcase
  end

  // Next values of every registered output and datapath register.
  always_comb begin
    w_idx  = r_idx;
    w_wait = r_wait;
    w_test = r_test;
    w_busy = r_busy;
    w_done = 1'b0;
    w_code = r_code;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_busy = 1'b1;
          w_code = FC_NONE;
          w_idx  = '0;
          w_wait = '0;
          w_test = '0;
        end
      end
      ST_LOAD: begin
        w_test = VECTORS[r_idx];
        w_wait = '0;
      end
      ST_SETTLE_WAIT: begin
        if (r_wait == LAST_WAIT) begin
          // Sample edge: only the first non-zero diagnosis is kept.
          w_wait = '0;
          if (r_code == FC_NONE) w_code = w_class;
        end else begin
          w_wait = r_wait + 4'd1;
        end
      end
      ST_SAMPLE: begin
        if (r_idx == 2'd3) begin
          w_test = '0;
          w_busy = 1'b0;
          w_done = 1'b1;
        end else begin
          w_idx  = r_idx + 2'd1;
          w_test = VECTORS[r_idx + 2'd1];
          w_wait = '0;
        end
      end
      ST_FINISH: begin
        w_test = '0;
      end
      default: begin
        w_test = '0;
        w_busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_wait  <= '0;
      r_test  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_code  <= '0;
      r_found <= 1'b0;
    end else begin
      r_idx   <= w_idx;
      r_wait  <= w_wait;
      r_test  <= w_test;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_code  <= w_code;
      r_found <= (w_code != FC_NONE);
    end
  end

  assign test_a      = r_test[2];
  assign test_b      = r_test[1];
  assign test_bin    = r_test[0];
  assign busy        = r_busy;
  assign done        = r_done;
  assign fault_code  = r_code;
  assign fault_found = r_found;

endmodule

// File: tb/tb_fs_fault_sequencer.sv
module tb_fs_fault_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       st1, st2, st15;
  logic [2:0] sa0;            // stuck-at-0 on DUT inputs {A,B,Bin}
  logic       de, dv, be, bv; // optional output stuck-at on D / Bout

  int unsigned total  = 0;
  int unsigned passed = 0;

  // Behavioural full subtractor with injected faults: A - B - Bin.
  function automatic logic [1:0] fs_resp(input logic a, b, bin,
      input logic [2:0] s, input logic d_en, d_val, b_en, b_val);
    int diff;
    diff = int'(a & ~s[2]) - int'(b & ~s[1]) - int'(bin & ~s[0]);
    fs_resp = {(d_en ? d_val : diff[0]), (b_en ? b_val : (diff < 0))};
  endfunction

  logic       ta1, tb1, tc1, bz1, dn1, ff1, d1, o1;
  logic       ta2, tb2, tc2, bz2, dn2, ff2, d2, o2;
  logic       ta15, tb15, tc15, bz15, dn15, ff15, d15, o15;
  logic [3:0] fc1, fc2, fc15;

  assign {d1, o1}   = fs_resp(ta1, tb1, tc1, sa0, de, dv, be, bv);
  assign {d2, o2}   = fs_resp(ta2, tb2, tc2, sa0, de, dv, be, bv);
  assign {d15, o15} = fs_resp(ta15, tb15, tc15, sa0, de, dv, be, bv);

  fs_fault_sequencer #(.SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .dut_d(d1), .dut_bout(o1),
    .test_a(ta1), .test_b(tb1), .test_bin(tc1), .busy(bz1), .done(dn1),
    .fault_code(fc1), .fault_found(ff1));
  fs_fault_sequencer #(.SETTLE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .dut_d(d2), .dut_bout(o2),
    .test_a(ta2), .test_b(tb2), .test_bin(tc2), .busy(bz2), .done(dn2),
    .fault_code(fc2), .fault_found(ff2));
  fs_fault_sequencer #(.SETTLE(15)) u15 (
    .clk(clk), .rst_n(rst_n), .start(st15), .dut_d(d15), .dut_bout(o15),
    .test_a(ta15), .test_b(tb15), .test_bin(tc15), .busy(bz15), .done(dn15),
    .fault_code(fc15), .fault_found(ff15));

  // Stimulus vectors, good responses and the diagnosis table.
  logic [2:0] tv [4] = '{3'b111, 3'b110, 3'b101, 3'b100};
  logic [1:0] tr [4] = '{2'b11, 2'b00, 2'b00, 2'b10};
  typedef struct {int k; logic [1:0] r; logic [3:0] c;} cls_t;
  cls_t cls [7] = '{'{0, 2'b01, 4'd1}, '{0, 2'b10, 4'd5}, '{1, 2'b10, 4'd2},
                    '{1, 2'b11, 4'd6}, '{2, 2'b10, 4'd3}, '{2, 2'b11, 4'd4},
                    '{3, 2'b00, 4'd7}};
  logic [3:0] kc [4];   // expected per-vector diagnosis for current faults

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_faults(input logic [2:0] s, input logic a, b, c, d);
    logic [1:0] r;
    sa0 = s; de = a; dv = b; be = c; bv = d;
    for (int k = 0; k < 4; k++) begin
      r = fs_resp(tv[k][2], tv[k][1], tv[k][0], s, a, b, c, d);
      kc[k] = 4'd0;
      if (r != tr[k]) begin
        kc[k] = 4'd8;
        for (int i = 0; i < 7; i++)
          if (cls[i].k == k && cls[i].r == r) kc[k] = cls[i].c;
      end
    end
  endtask

  // r = cycles since the accepted start edge, sampled mid-cycle.
  task automatic chk_inst(input string nm, input int s, input int r,
      input logic [2:0] t, input logic bz, dn, input logic [3:0] fc, input logic ff);
    int fin = 4 * (s + 1);
    logic [3:0] ec = 4'd0;
    chk($sformatf("%s r%0d busy", nm, r), 16'(bz), 16'(r >= 0 && r <= fin));
    chk($sformatf("%s r%0d done", nm, r), 16'(dn), 16'(r == fin + 1));
    if (r > 0 && r <= fin) begin
      if ((r - 1) % (s + 1) < s)
        chk($sformatf("%s r%0d vec", nm, r), 16'(t), 16'(tv[(r - 1) / (s + 1)]));
    end else if (r != 0) begin
      chk($sformatf("%s r%0d vec", nm, r), 16'(t), 16'h0);
    end
    for (int k = 0; k < 4; k++)
      if (r >= (k + 1) * (s + 1) && ec == 4'd0) ec = kc[k];
    chk($sformatf("%s r%0d code", nm, r), 16'(fc), 16'(ec));
    chk($sformatf("%s r%0d found", nm, r), 16'(ff), 16'(ec != 4'd0));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " u1"},  {6'd0, ta1, tb1, tc1, bz1, dn1, fc1, ff1}, 16'h0);
    chk({tag, " u2"},  {6'd0, ta2, tb2, tc2, bz2, dn2, fc2, ff2}, 16'h0);
    chk({tag, " u15"}, {6'd0, ta15, tb15, tc15, bz15, dn15, fc15, ff15}, 16'h0);
  endtask

  task automatic run(input logic [2:0] s, input logic a, b, c, d, input bit glitch);
    set_faults(s, a, b, c, d);
    @(negedge clk);
    st1 = 1'b1; st2 = 1'b1; st15 = 1'b1;
    for (int r = 0; r <= 66; r++) begin
      @(negedge clk);
      if (r == 0) begin st1 = 1'b0; st2 = 1'b0; st15 = 1'b0; end
      chk_inst("s1",  1,  r, {ta1, tb1, tc1},    bz1,  dn1,  fc1,  ff1);
      chk_inst("s2",  2,  r, {ta2, tb2, tc2},    bz2,  dn2,  fc2,  ff2);
      chk_inst("s15", 15, r, {ta15, tb15, tc15}, bz15, dn15, fc15, ff15);
      // start pulses while busy and in the FINISH cycle of the SETTLE=2 unit
      if (glitch) st2 = (r == 4 || r == 13);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    st1 = 1'b0; st2 = 1'b0; st15 = 1'b0;
    set_faults(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    run(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // fault-free
    run(3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);  // A s-a-0, start glitches
    run(3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // B,Bin s-a-0
    run(3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // B s-a-0
    run(3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // all inputs s-a-0
    run(3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);  // D stuck at 1

    // Reset during vector k2 of the SETTLE=2 unit, then a clean restart.
    set_faults(3'b100, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    st1 = 1'b1; st2 = 1'b1; st15 = 1'b1;
    @(negedge clk);
    st1 = 1'b0; st2 = 1'b0; st15 = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      chk($sformatf("after reset c%0d idle", i),
          {13'd0, bz1 | bz2 | bz15, dn1 | dn2 | dn15, ff1 | ff2 | ff15}, 16'h0);
    end
    run(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 8; n++)
      run(3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), 1'($urandom),
          ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
